router_fsm_ctrl: RTL
====================

// Module: router_fsm_ctrl
// PURPOSE
//  Packet-reception controller for the 1x3 router. Sequences header decode, payload load,
//  FIFO-full stall and parity check for each incoming packet. Drives the router's register
//  block and synchronizer: detect_addr latches the destination, write_enb_reg gates FIFO writes.
//  Sits between the input pins (pkt_valid, din) and the synchronizer/register block.
// PARAMETERS
//  WAIT_TIMEOUT  64  cycles in WAIT_TILL_EMPTY before the packet is dropped (ROUTER_FSM_TIMEOUT_EN only)
//  CNT_W         7   width of the timeout counter; must satisfy 2**CNT_W > WAIT_TIMEOUT
// PORTS
//  clk            in   1  clock, all state on rising edge
//  rst            in   1  synchronous, active-low reset
//  pkt_valid      in   1  high while header and payload bytes are on the input; falls on the parity byte
//  din            in   2  destination address, i.e. header bits [1:0]; sampled in DECODE_ADDRESS
//  fifo_full      in   1  full flag of the selected FIFO (from synchronizer)
//  fifo_empty_0/1/2 in 1  empty flags of output FIFOs 0..2
//  soft_reset_0/1/2 in 1  per-port read-timeout soft resets (from synchronizer)
//  parity_done    in   1  register block has captured the parity byte
//  low_pkt_valid  in   1  register block saw pkt_valid fall while stalled
//  detect_addr    out  1  state == DECODE_ADDRESS
//  lfd_state      out  1  state == LOAD_FIRST_DATA (header write)
//  ld_state       out  1  state == LOAD_DATA
//  laf_state      out  1  state == LOAD_AFTER_FULL
//  full_state     out  1  state == FIFO_FULL_STATE
//  write_enb_reg  out  1  state in {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}
//  rst_int_reg    out  1  state == CHECK_PARITY_ERROR
//  busy           out  1  high in every state except DECODE_ADDRESS and LOAD_DATA
//  drop_pkt       out  1  one-cycle pulse when a packet is abandoned on timeout
// BEHAVIOUR
//  - Moore FSM; all outputs decode combinationally from the registered state, no output registers.
//  - Reset (rst==0 at posedge): state=DECODE_ADDRESS, addr_q=0, timeout count=0.
//    Outputs: detect_addr=1, all others 0.
//  - addr_q <= din on any cycle in DECODE_ADDRESS with pkt_valid=1. Selects the port whose empty
//    flag and soft reset are watched in later states.
//  - DECODE_ADDRESS: pkt_valid & din==k (k<3) & fifo_empty_k -> LOAD_FIRST_DATA;
//    pkt_valid & din==k & !fifo_empty_k -> WAIT_TILL_EMPTY;
//    din==3 or !pkt_valid -> stay. Address 3 is discarded byte-by-byte, never written.
//  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
//  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
//    fifo_full has priority when both conditions hold.
//  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
//  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY;
//    else -> LOAD_DATA.
//  - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
//  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
//  - WAIT_TILL_EMPTY: fifo_empty_{addr_q} -> LOAD_FIRST_DATA; else stay.
//  - Soft reset: soft_reset_{addr_q}=1 in any state other than DECODE_ADDRESS
//    -> DECODE_ADDRESS next cycle. Overrides all other transitions except rst.
//    Soft resets of non-selected ports are ignored.
//  - Header-to-payload latency: header in DECODE_ADDRESS at cycle n; lfd_state=1 at n+1;
//    ld_state=1 at n+2.
//  - Reset mid-packet: return to DECODE_ADDRESS immediately; the partial packet is not
//    completed.
//  - Illegal state encodings recover to DECODE_ADDRESS (default arm).
// CONFIGURATION
//  ROUTER_FSM_TIMEOUT_EN defined:
//   - Counter clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
//   - When the count reaches WAIT_TIMEOUT with the FIFO still non-empty:
//     -> DECODE_ADDRESS, drop_pkt=1 for exactly that transition cycle.
//   - fifo_empty in the same cycle wins: -> LOAD_FIRST_DATA, no drop.
//  ROUTER_FSM_TIMEOUT_EN undefined:
//   - No counter; WAIT_TILL_EMPTY waits indefinitely; drop_pkt tied to 0.
// TESTING
//  T1 reset: rst=0 for 2 cycles -> detect_addr=1, busy=0, write_enb_reg=0, drop_pkt=0.
//  T2 normal packet: din=2'b01, fifo_empty_1=1, pkt_valid high 5 cycles
//     -> lfd_state 1 cycle, ld_state 4 cycles, LOAD_PARITY, rst_int_reg 1 cycle, detect_addr.
//  T3 FIFO full: fifo_full=1 mid-LOAD_DATA for 3 cycles -> full_state=1, busy=1, write_enb_reg=0;
//     fifo_full drops -> laf_state 1 cycle -> LOAD_DATA.
//  T4 busy port: din=2'b10, fifo_empty_2=0 for 10 cycles -> busy=1 throughout, no lfd_state;
//     fifo_empty_2 rises -> lfd_state next cycle.
//  T5 soft reset: soft_reset_0=1 during LOAD_DATA to port 0 -> detect_addr=1 next cycle;
//     soft_reset_1 pulse during that same packet -> no effect.
//  T6 timeout (macro on, WAIT_TIMEOUT=4): fifo_empty_0 held 0
//     -> drop_pkt pulse after 4 cycles in WAIT_TILL_EMPTY, then DECODE_ADDRESS; macro off -> waits.

Source files
------------

// File: rtl/router_fsm_ctrl.sv
// Purpose : packet-reception controller for the 1x3 router (header decode, payload load,
//           FIFO-full stall, parity check) driving the register block and synchronizer.
// Latency : Moore FSM; header seen in DECODE_ADDRESS at cycle n -> lfd_state at n+1, ld_state at n+2.
// Backpressure: fifo_full stalls the packet in FIFO_FULL_STATE; a busy destination FIFO holds the
//           header in WAIT_TILL_EMPTY (optionally abandoned after WAIT_TIMEOUT cycles).
//
// Ports:
//   clk, rst                  clock (rising edge) and synchronous active-low reset
//   pkt_valid, din[1:0]       packet framing and destination address (header bits [1:0])
//   fifo_full                 full flag of the selected FIFO
//   fifo_empty_0/1/2          empty flags of output FIFOs
//   soft_reset_0/1/2          per-port read-timeout soft resets
//   parity_done, low_pkt_valid  status from the register block
//   detect_addr, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy
//                             state decodes for register block / synchronizer
//   drop_pkt                  one-cycle pulse when a waiting packet is abandoned on timeout
//
// Build option: define ROUTER_FSM_TIMEOUT_EN to enable the WAIT_TILL_EMPTY timeout; when
// undefined the FSM waits indefinitely and drop_pkt is tied low.

module router_fsm_ctrl #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] din,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       drop_pkt
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [1:0] addr_q;
  logic       din_empty;   // empty flag of the port addressed by the incoming header
  logic       sel_empty;   // empty flag of the latched destination
  logic       sel_soft;    // soft reset of the latched destination
  logic       timed_out;

  // Header address selects the empty flag directly; address 3 never matches.
  always_comb begin
    din_empty = 1'b0;
    case (din)
      2'd0:    din_empty = fifo_empty_0;
      2'd1:    din_empty = fifo_empty_1;
      2'd2:    din_empty = fifo_empty_2;
      default: din_empty = 1'b0;
    endcase
  end

  // addr_q can only be 3 while in DECODE_ADDRESS, where these selects are not used.
  always_comb begin
    sel_empty = fifo_empty_0;
    sel_soft  = soft_reset_0;
    case (addr_q)
      2'd1: begin
        sel_empty = fifo_empty_1;
        sel_soft  = soft_reset_1;
      end
      2'd2: begin
        sel_empty = fifo_empty_2;
        sel_soft  = soft_reset_2;
      end
      default: begin
        sel_empty = fifo_empty_0;
        sel_soft  = soft_reset_0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      addr_q <= 2'd0;
    else if (state == DECODE_ADDRESS && pkt_valid)
      addr_q <= din;
  end

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  // Cleared on entry to WAIT_TILL_EMPTY, counts every cycle spent there.
  always_ff @(posedge clk) begin
    if (!rst)
      wait_cnt <= '0;
    else if (state != WAIT_TILL_EMPTY && next_state == WAIT_TILL_EMPTY)
      wait_cnt <= '0;
    else if (state == WAIT_TILL_EMPTY)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT_TILL_EMPTY) && (wait_cnt == CNT_W'(WAIT_TIMEOUT));
  // An empty FIFO or a soft reset in the same cycle means the packet is not dropped.
  assign drop_pkt  = timed_out && !sel_empty && !sel_soft;
`else
  assign timed_out = 1'b0;
  assign drop_pkt  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst)
      state <= DECODE_ADDRESS;
    else
      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid && din != 2'd3)
          next_state = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)
          next_state = FIFO_FULL_STATE;
        else if (!pkt_valid)
          next_state = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full)
          next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)
          next_state = DECODE_ADDRESS;
        else if (low_pkt_valid)
          next_state = LOAD_PARITY;
        else
          next_state = LOAD_DATA;
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (sel_empty)
          next_state = LOAD_FIRST_DATA;
        else if (timed_out)
          next_state = DECODE_ADDRESS;
      end
      default: next_state = DECODE_ADDRESS;
    endcase
    // A soft reset of the destination port abandons the packet from any active state.
    if (state != DECODE_ADDRESS && sel_soft)
      next_state = DECODE_ADDRESS;
  end

  // Output decode
  always_comb begin
    detect_addr   = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    case (state)
      DECODE_ADDRESS: begin
        detect_addr = 1'b1;
        busy        = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      LOAD_PARITY: write_enb_reg = 1'b1;
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      WAIT_TILL_EMPTY: busy = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default: busy = 1'b1;
    endcase
  end

endmodule
